// File: rtl/cdc_bus_sender.sv
// Source-domain half of a toggle (two-phase) req/ack bus synchronizer.
// A word accepted on in_valid/in_ready is held on tx_data while tx_req toggles.
// The block then waits for the destination's rx_ack toggle, which arrives
// through a plain flop chain. It also reports ack timeouts, spurious acks and
// a count of completed transfers.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transfer outstanding, in_ready high
// WAIT_ACK | tx_req toggled, waiting for synchronized ack to match tx_req
module cdc_bus_sender #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 tx_req,
    output logic [WIDTH-1:0]     tx_data,
    input  logic                 rx_ack,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 proto_err,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tx_req_q, tx_req_d;
    logic [WIDTH-1:0]       tx_data_q, tx_data_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   proto_err_q, proto_err_d;
    logic [CNT_WIDTH-1:0]   xfer_cnt_q, xfer_cnt_d;

    logic ack_s;
    logic ack_edge;
    logic match;

    assign ack_s    = sync_q[SYNC_STAGES-1];
    // ack_s is about to take the value of the previous stage; a difference means
    // ack_s changes on this edge.
    assign ack_edge = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
    assign match    = (ack_s == tx_req_q);

    // Bring rx_ack into the clk domain; pure shift, no logic between stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_ack};
        end
    end

    // Next-state, hold/launch of the request, timeout and status decode.
    always_comb begin
        state_d       = state_q;
        tx_req_d      = tx_req_q;
        tx_data_d     = tx_data_q;
        to_cnt_d      = to_cnt_q;
        xfer_cnt_d    = xfer_cnt_q;
        timeout_err_d = 1'b0;
        proto_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                proto_err_d = ack_edge;
                if (in_valid) begin
                    tx_data_d = in_data;
                    tx_req_d  = ~tx_req_q;
                    to_cnt_d  = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (match) begin
                    state_d    = IDLE;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                end else if ((TIMEOUT_CYCLES > 0) && (to_cnt_q != TO_LIMIT)) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    // Fires only on the step that reaches the limit; saturation
                    // prevents a second pulse for the same transfer.
                    if (to_cnt_q == TO_LIMIT - TW'(1)) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also drops tx_req back to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tx_req_q      <= 1'b0;
            tx_data_q     <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
            xfer_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            tx_req_q      <= tx_req_d;
            tx_data_q     <= tx_data_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
            xfer_cnt_q    <= xfer_cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == WAIT_ACK);
    assign tx_req      = tx_req_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;
    assign xfer_cnt    = xfer_cnt_q;

endmodule
